dmem_port_ctrl: RTL
===================

# dmem_port_ctrl

Two-core request front end that sits directly upstream of the data memory and drives its per-core address, data, load and write lines. It accepts one valid/ready request per core per cycle. Colliding writes to the shared region are serialised with rotating priority, so the memory never sees two shared writes in the same cycle. Load data is returned to each core on a one-cycle response pulse.

## Interface
Parameters:
- TAM, 16, data and address width.
- Lmem, 8, local index width. Address bit Lmem selects the shared region (1) or the core's private region (0).

Ports:
- clk  in  1  system clock. The memory acts on the falling edge; this block acts on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqValid0 / reqValid1  in  1  core request valid.
- reqWrite0 / reqWrite1  in  1  1 = store, 0 = load.
- reqAddr0 / reqAddr1  in  TAM  request address.
- reqData0 / reqData1  in  TAM  store data.
- reqReady0 / reqReady1  out  1  request accepted this cycle (combinational).
- rspValid0 / rspValid1  out  1  one-cycle load-data pulse.
- rspData0 / rspData1  out  TAM  load data, held until the next pulse.
- errFlag  out  2  sticky out-of-range flag, one bit per core.
- dataADDR0 / dataADDR1  out  TAM  memory address (registered).
- dataIN0 / dataIN1  out  TAM  memory write data (registered).
- dataLoad  out  2  memory load strobe per core (registered).
- dataWrite  out  2  memory write strobe per core (registered).
- dataOUT0 / dataOUT1  in  TAM  memory read data.

## Operation
- A request is shared when reqAddr[Lmem] = 1.
- **Shared-write conflict:** both cores request valid shared writes in the same cycle.
  - Only the core named by prio gets reqReady = 1; the other gets 0.
  - The losing core must hold its request stable until it is accepted.
- **Read-after-write hazard:** one core issues a shared load whose low Lmem bits match a simultaneous accepted shared write from the other core.
  - The load is stalled one cycle, so it returns the new data.
- All other combinations are accepted in the same cycle (reqReady = reqValid).
- **Priority (prio):** a one-bit register.
  - After every conflict or hazard stall, prio moves to the stalled core.
  - No other event changes prio.
  - A core therefore waits at most one cycle.
- **Accept:** on a rising edge with reqValid & reqReady, the block registers:
  - dataADDR = reqAddr;
  - dataIN = reqData;
  - dataWrite[i] = reqWrite;
  - dataLoad[i] = ~reqWrite.
- **No accept:** when nothing is accepted, dataLoad[i] and dataWrite[i] clear to 0. dataADDR and dataIN hold their values.
- A registered load marks a pending-response bit for that core.
- At the next rising edge:
  - rspData = dataOUT, captured from the memory's falling-edge read;
  - rspValid pulses for one cycle.
- Responses cannot be back-pressured.

## Timing
- Load accepted at edge N:
  - strobes are active during cycle N to N+1;
  - the memory reads on the falling edge in that cycle;
  - rspValid is high from edge N+1 to N+2.
- Load-to-data latency is 1 cycle. Back-to-back loads give a response every cycle.
- A store accepted at edge N is written to memory at the falling edge before edge N+1. A load accepted at edge N+1 sees that data.
- reqReady depends combinationally on both cores' reqValid, reqWrite and reqAddr, and on prio.
- Reset values: all strobes 0; dataADDR, dataIN and rspData 0; rspValid 0; errFlag 0; prio 0 (core 0 first).
- Reset asserted mid-operation:
  - pending responses are discarded, with no rspValid after reset is released;
  - strobes drop immediately.

## Configuration
- DMEM_RANGE_CHECK_EN defined:
  - A request with any nonzero bit in reqAddr[TAM-1:Lmem+1] is accepted (reqReady = 1) but no strobe is issued.
  - The core's errFlag bit is set and stays set until reset.
  - A load gets rspValid one cycle later with rspData = all ones.
- DMEM_RANGE_CHECK_EN undefined:
  - The upper address bits are ignored and passed through.
  - errFlag is tied to 0.

## Test plan
- Core 0 stores 0x1234 to 0x0005, then loads 0x0005 → rspValid0 one cycle after the load is accepted, rspData0 = 0x1234.
- Both cores store to shared 0x0110 (values 0xAAAA and 0xBBBB) with prio = 0 → reqReady0 = 1 and reqReady1 = 0 in that cycle. Core 1 is accepted next cycle, and a load of 0x0110 then returns 0xBBBB.
- Repeat the conflict for 4 consecutive cycles → grants alternate 0, 1, 0, 1, and no request waits more than one cycle.
- Core 0 stores 0x5A5A to shared 0x0120 while core 1 loads 0x0120 → core 1 is stalled one cycle; rspData1 = 0x5A5A.
- Core 0 and core 1 each load private address 0x0003 holding distinct values (0x0011, 0x0022) in the same cycle → both accepted, and both responses arrive in the same cycle with the correct values.
- With DMEM_RANGE_CHECK_EN defined, core 1 loads 0x0400 → no dataLoad[1] strobe, rspData1 = 0xFFFF, errFlag = 2'b10. Assert reset mid-burst → all outputs return to 0.

Source files
------------

// File: rtl/dmem_port_ctrl_if.sv
// Request/response and data-memory signal bundle for dmem_port_ctrl.
// slave = the controller, master = the cores plus the data memory.
interface dmem_port_ctrl_if #(
    parameter int TAM = 16
);
    logic           reqValid0, reqValid1;
    logic           reqWrite0, reqWrite1;
    logic [TAM-1:0] reqAddr0, reqAddr1;
    logic [TAM-1:0] reqData0, reqData1;
    logic           reqReady0, reqReady1;
    logic           rspValid0, rspValid1;
    logic [TAM-1:0] rspData0, rspData1;
    logic [1:0]     errFlag;
    logic [TAM-1:0] dataADDR0, dataADDR1;
    logic [TAM-1:0] dataIN0, dataIN1;
    logic [1:0]     dataLoad, dataWrite;
    logic [TAM-1:0] dataOUT0, dataOUT1;

    modport slave (
        input  reqValid0, reqValid1, reqWrite0, reqWrite1,
        input  reqAddr0, reqAddr1, reqData0, reqData1,
        input  dataOUT0, dataOUT1,
        output reqReady0, reqReady1, rspValid0, rspValid1,
        output rspData0, rspData1, errFlag,
        output dataADDR0, dataADDR1, dataIN0, dataIN1, dataLoad, dataWrite
    );

    modport master (
        output reqValid0, reqValid1, reqWrite0, reqWrite1,
        output reqAddr0, reqAddr1, reqData0, reqData1,
        output dataOUT0, dataOUT1,
        input  reqReady0, reqReady1, rspValid0, rspValid1,
        input  rspData0, rspData1, errFlag,
        input  dataADDR0, dataADDR1, dataIN0, dataIN1, dataLoad, dataWrite
    );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Two-core front end for the data memory: serialises shared-region writes with rotating priority.
// Optional out-of-range address trapping is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_port_ctrl #(
    parameter int TAM  = 16,
    parameter int Lmem = 8
) (
    input logic             clk,
    input logic             rst,
    dmem_port_ctrl_if.slave bus
);
    logic [1:0]     valid, write, ready, oor;
    logic [1:0]     in_shared, wr_shared, ld_shared, hazard;
    logic [TAM-1:0] addr  [2];
    logic [TAM-1:0] wdata [2];
    logic [TAM-1:0] rdata [2];
    logic           conflict, low_match, prio;

    logic [1:0]     load_p1, write_p1, oor_ld_p1, err_p1;
    logic [TAM-1:0] addr_p1 [2];
    logic [TAM-1:0] din_p1  [2];
    logic [1:0]     rsp_vld_p2;
    logic [TAM-1:0] rsp_p2  [2];

    assign valid    = {bus.reqValid1, bus.reqValid0};
    assign write    = {bus.reqWrite1, bus.reqWrite0};
    assign addr[0]  = bus.reqAddr0;
    assign addr[1]  = bus.reqAddr1;
    assign wdata[0] = bus.reqData0;
    assign wdata[1] = bus.reqData1;
    assign rdata[0] = bus.dataOUT0;
    assign rdata[1] = bus.dataOUT1;

`ifdef DMEM_RANGE_CHECK_EN
    assign oor[0] = |addr[0][TAM-1:Lmem+1];
    assign oor[1] = |addr[1][TAM-1:Lmem+1];
`else
    assign oor = 2'b00;
`endif

    // Trapped requests never reach the memory, so they take no part in arbitration.
    assign in_shared = {addr[1][Lmem], addr[0][Lmem]} & ~oor;
    assign wr_shared = valid & write & in_shared;
    assign ld_shared = valid & ~write & in_shared;
    assign low_match = (addr[0][Lmem-1:0] == addr[1][Lmem-1:0]);
    assign conflict  = &wr_shared;
    assign hazard[0] = ld_shared[0] & wr_shared[1] & low_match;
    assign hazard[1] = ld_shared[1] & wr_shared[0] & low_match;

    assign ready[0] = valid[0] & ~(conflict & prio)  & ~hazard[0];
    assign ready[1] = valid[1] & ~(conflict & ~prio) & ~hazard[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio       <= 1'b0;
            load_p1    <= 2'b00;
            write_p1   <= 2'b00;
            oor_ld_p1  <= 2'b00;
            err_p1     <= 2'b00;
            rsp_vld_p2 <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                addr_p1[i] <= '0;
                din_p1[i]  <= '0;
                rsp_p2[i]  <= '0;
            end
        end else begin
            // Priority hands over to whichever core was just held back.
            if (conflict)       prio <= ~prio;
            else if (hazard[0]) prio <= 1'b0;
            else if (hazard[1]) prio <= 1'b1;

            for (int i = 0; i < 2; i++) begin
                // Stage p1: memory strobes, address and write data
                load_p1[i]   <= ready[i] & ~write[i] & ~oor[i];
                write_p1[i]  <= ready[i] &  write[i] & ~oor[i];
                oor_ld_p1[i] <= ready[i] & ~write[i] &  oor[i];
                if (ready[i]) begin
                    addr_p1[i] <= addr[i];
                    din_p1[i]  <= wdata[i];
                end
                if (ready[i] & oor[i]) err_p1[i] <= 1'b1;

                // Stage p2: load data captured after the memory's falling-edge read
                rsp_vld_p2[i] <= load_p1[i] | oor_ld_p1[i];
                if (load_p1[i])        rsp_p2[i] <= rdata[i];
                else if (oor_ld_p1[i]) rsp_p2[i] <= '1;
            end
        end
    end

    assign bus.reqReady0 = ready[0];
    assign bus.reqReady1 = ready[1];
    assign bus.dataLoad  = load_p1;
    assign bus.dataWrite = write_p1;
    assign bus.dataADDR0 = addr_p1[0];
    assign bus.dataADDR1 = addr_p1[1];
    assign bus.dataIN0   = din_p1[0];
    assign bus.dataIN1   = din_p1[1];
    assign bus.rspValid0 = rsp_vld_p2[0];
    assign bus.rspValid1 = rsp_vld_p2[1];
    assign bus.rspData0  = rsp_p2[0];
    assign bus.rspData1  = rsp_p2[1];
    assign bus.errFlag   = err_p1;
endmodule
